// File: rtl/n64_gamma_corr.sv
// Two-stage per-channel quadratic gamma correction for the N64 VCLK video path.
// Optional GAMMA_BLANK_ZERO_EN: zero the colour words while nCLAMP (S[2]) is low.
module n64_gamma_corr #(
    parameter int COLOR_W = 7
) (
    input  logic                      VCLK,
    input  logic                      RST,
    input  logic                      nVDSYNC,
    input  logic [3:0]                gammaparams_i,
    input  logic [3*COLOR_W+4-1:0]    video_data_i,
    output logic [3*COLOR_W+4-1:0]    video_data_o
);

    localparam int DW  = 3*COLOR_W + 4;
    localparam int P_W = 2*COLOR_W + 5;
    localparam int SH  = COLOR_W + 3;

    // p = s * x * (MAXV - x); MAXV - x is simply ~x because MAXV is all ones
    function automatic logic [P_W-1:0] curve_prod(input logic signed [3:0] s,
                                                  input logic [COLOR_W-1:0] x);
        logic [2*COLOR_W-1:0]  m;
        logic signed [P_W-1:0] s_ext;
        logic signed [P_W-1:0] m_ext;
        m     = {{COLOR_W{1'b0}}, x} * {{COLOR_W{1'b0}}, ~x};
        s_ext = P_W'(s);
        m_ext = signed'({{(P_W-2*COLOR_W){1'b0}}, m});
        return s_ext * m_ext;
    endfunction

    function automatic logic [COLOR_W-1:0] clamp_sum(input logic [COLOR_W-1:0] x,
                                                     input logic [P_W-1:0] p);
        logic signed [P_W-1:0] y;
        y = signed'({{(P_W-COLOR_W){1'b0}}, x}) + (signed'(p) >>> SH);
        if (y < 0) begin
            return {COLOR_W{1'b0}};
        end else if (y > signed'({{(P_W-COLOR_W){1'b0}}, {COLOR_W{1'b1}}})) begin
            return {COLOR_W{1'b1}};
        end else begin
            return y[COLOR_W-1:0];
        end
    endfunction

    logic [3:0]                code_q, code_d;
    logic [2:0][COLOR_W-1:0]   x1_q, x1_d;
    logic [2:0][P_W-1:0]       p1_q, p1_d;
    logic [3:0]                sync1_q, sync1_d;
    logic [DW-1:0]             out_q, out_d;
    logic [3:0]                g_use;
    logic signed [3:0]         s_val;
    logic [2:0][COLOR_W-1:0]   col_d;

    // Next-state: code latch on vsync, stage-1 product, stage-2 shift/clamp
    always_comb begin
        code_d = code_q;
        g_use  = code_q;
        if (!nVDSYNC && !video_data_i[3]) begin
            code_d = gammaparams_i;
            g_use  = gammaparams_i;
        end else begin
            code_d = code_q;
            g_use  = code_q;
        end
        // g - 8 in two's complement is g with its MSB inverted
        s_val   = signed'({~g_use[3], g_use[2:0]});
        sync1_d = video_data_i[3:0];
        for (int c = 0; c < 3; c++) begin
            x1_d[c]  = video_data_i[DW-1-c*COLOR_W -: COLOR_W];
            p1_d[c]  = curve_prod(s_val, x1_d[c]);
            col_d[c] = clamp_sum(x1_q[c], p1_q[c]);
        end
`ifdef GAMMA_BLANK_ZERO_EN
        if (!sync1_q[2]) begin
            col_d = '0;
        end else begin
            col_d = col_d;
        end
`endif
        out_d = {col_d[0], col_d[1], col_d[2], sync1_q};
    end

    // Pipeline registers advance only on enabled edges
    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            code_q  <= 4'd8;
            x1_q    <= '0;
            p1_q    <= '0;
            sync1_q <= 4'd0;
            out_q   <= '0;
        end else if (!nVDSYNC) begin
            code_q  <= code_d;
            x1_q    <= x1_d;
            p1_q    <= p1_d;
            sync1_q <= sync1_d;
            out_q   <= out_d;
        end
    end

    assign video_data_o = out_q;

endmodule

// File: tb/tb_n64_gamma_corr.sv
// Directed self-checking bench for n64_gamma_corr (COLOR_W = 7).
module tb_n64_gamma_corr;

    logic        VCLK;
    logic        RST;
    logic        nVDSYNC;
    logic [3:0]  gammaparams_i;
    logic [24:0] video_data_i;
    logic [24:0] video_data_o;

    int checks = 0;
    int passed = 0;

    n64_gamma_corr #(.COLOR_W(7)) dut (
        .VCLK          (VCLK),
        .RST           (RST),
        .nVDSYNC       (nVDSYNC),
        .gammaparams_i (gammaparams_i),
        .video_data_i  (video_data_i),
        .video_data_o  (video_data_o)
    );

    initial begin
        VCLK = 1'b0;
        forever #5 VCLK = ~VCLK;
    end

    function automatic logic [24:0] pack(input logic [6:0] r, input logic [6:0] g,
                                         input logic [6:0] b, input logic [3:0] s);
        return {r, g, b, s};
    endfunction

    task automatic step();
        @(posedge VCLK);
        #1;
    endtask

    task automatic test_reset();
        logic [24:0] exp;
        RST = 1'b1;
        nVDSYNC = 1'b0;
        gammaparams_i = 4'd8;
        video_data_i = pack(7'd63, 7'd63, 7'd63, 4'hF);
        #1;
        checks++;
        if (video_data_o !== 25'd0) $display("FAIL reset_out got %h exp %h", video_data_o, 25'd0);
        else passed++;
        #3 RST = 1'b0;
        step(); step();
        exp = pack(7'd63, 7'd63, 7'd63, 4'hF);
        checks++;
        if (video_data_o !== exp) $display("FAIL reset_first_pixel got %h exp %h", video_data_o, exp);
        else passed++;
    endtask

    task automatic test_bypass();
        logic [24:0] exp;
        video_data_i = pack(7'd0, 7'd63, 7'd127, 4'hF);
        step(); step();
        exp = pack(7'd0, 7'd63, 7'd127, 4'hF);
        checks++;
        if (video_data_o !== exp) $display("FAIL bypass got %h exp %h", video_data_o, exp);
        else passed++;
    endtask

    task automatic test_gamma_pos();
        logic [24:0] exp;
        gammaparams_i = 4'd15;
        video_data_i = pack(7'd63, 7'd0, 7'd127, 4'h7);
        step(); step();
        exp = pack(7'd90, 7'd0, 7'd127, 4'h7);
        checks++;
        if (video_data_o !== exp) $display("FAIL g15_a got %h exp %h", video_data_o, exp);
        else passed++;
        video_data_i = pack(7'd32, 7'd63, 7'd0, 4'hF);
        step(); step();
        exp = pack(7'd52, 7'd90, 7'd0, 4'hF);
        checks++;
        if (video_data_o !== exp) $display("FAIL g15_b got %h exp %h", video_data_o, exp);
        else passed++;
    endtask

    task automatic test_gamma_neg();
        logic [24:0] exp;
        gammaparams_i = 4'd0;
        video_data_i = pack(7'd63, 7'd1, 7'd126, 4'h7);
        step(); step();
        exp = pack(7'd31, 7'd0, 7'd125, 4'h7);
        checks++;
        if (video_data_o !== exp) $display("FAIL g0 got %h exp %h", video_data_o, exp);
        else passed++;
    endtask

    task automatic test_gating();
        logic [24:0] exp;
        gammaparams_i = 4'd15;
        video_data_i = pack(7'd63, 7'd63, 7'd63, 4'hF);
        step(); step();
        exp = pack(7'd31, 7'd31, 7'd31, 4'hF);
        checks++;
        if (video_data_o !== exp) $display("FAIL no_latch_midframe got %h exp %h", video_data_o, exp);
        else passed++;
        nVDSYNC = 1'b1;
        video_data_i = pack(7'd0, 7'd0, 7'd0, 4'h7);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (video_data_o !== exp) $display("FAIL frozen got %h exp %h", video_data_o, exp);
        else passed++;
        nVDSYNC = 1'b0;
        video_data_i = pack(7'd63, 7'd63, 7'd63, 4'h7);
        step(); step();
        exp = pack(7'd90, 7'd90, 7'd90, 4'h7);
        checks++;
        if (video_data_o !== exp) $display("FAIL latch_on_vsync got %h exp %h", video_data_o, exp);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [24:0] exp;
        video_data_i = pack(7'd32, 7'd32, 7'd32, 4'hF);
        step();
        video_data_i = pack(7'd0, 7'd127, 7'd63, 4'hE);
        step();
        exp = pack(7'd52, 7'd52, 7'd52, 4'hF);
        checks++;
        if (video_data_o !== exp) $display("FAIL b2b_0 got %h exp %h", video_data_o, exp);
        else passed++;
        video_data_i = pack(7'd63, 7'd0, 7'd32, 4'hD);
        nVDSYNC = 1'b1;
        step();
        checks++;
        if (video_data_o !== exp) $display("FAIL b2b_hold got %h exp %h", video_data_o, exp);
        else passed++;
        nVDSYNC = 1'b0;
        step();
        exp = pack(7'd0, 7'd127, 7'd90, 4'hE);
        checks++;
        if (video_data_o !== exp) $display("FAIL b2b_1 got %h exp %h", video_data_o, exp);
        else passed++;
        step();
        exp = pack(7'd90, 7'd0, 7'd52, 4'hD);
        checks++;
        if (video_data_o !== exp) $display("FAIL b2b_2 got %h exp %h", video_data_o, exp);
        else passed++;
    endtask

    task automatic test_blank();
        logic [24:0] exp;
        video_data_i = pack(7'd100, 7'd100, 7'd100, 4'b1011);
        step(); step();
`ifdef GAMMA_BLANK_ZERO_EN
        exp = pack(7'd0, 7'd0, 7'd0, 4'b1011);
`else
        exp = pack(7'd118, 7'd118, 7'd118, 4'b1011);
`endif
        checks++;
        if (video_data_o !== exp) $display("FAIL blank got %h exp %h", video_data_o, exp);
        else passed++;
    endtask

    task automatic test_reset_midframe();
        logic [24:0] exp;
        #2 RST = 1'b1;
        #1;
        checks++;
        if (video_data_o !== 25'd0) $display("FAIL mid_reset got %h exp %h", video_data_o, 25'd0);
        else passed++;
        RST = 1'b0;
        gammaparams_i = 4'd15;
        video_data_i = pack(7'd63, 7'd63, 7'd63, 4'hF);
        step(); step();
        exp = pack(7'd63, 7'd63, 7'd63, 4'hF);
        checks++;
        if (video_data_o !== exp) $display("FAIL code_reset_bypass got %h exp %h", video_data_o, exp);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_gamma_pos();
        test_gamma_neg();
        test_gating();
        test_back_to_back();
        test_blank();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
